// File: rtl/birth_digit_scroller.sv
// Scrolling six-digit BCD window over a loaded digit sequence followed by a blank gap.
// Feeds six 7-segment decoders; BLANK renders as all segments off.
module birth_digit_scroller #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned STEP_HZ    = 2,
  parameter int unsigned NUM_DIGITS = 8,
  parameter logic [3:0]  BLANK      = 4'hF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    run,
  output logic [23:0]             disp_bcd,
  output logic                    step_pulse,
  output logic [1:0]              state
);

  localparam int unsigned DIV = CLK_HZ / STEP_HZ;
  localparam int unsigned L   = NUM_DIGITS + 6;
  localparam int unsigned PW  = $clog2(L);
  localparam int unsigned DW  = $clog2(DIV);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHOW   = 2'b01,
    SCROLL = 2'b10
  } state_t;

  state_t                  st, st_n;
  logic [4*NUM_DIGITS-1:0] digits, digits_n;
  logic [PW-1:0]           pos, pos_n;
  logic [DW-1:0]           presc, presc_n;
  logic                    step_n;
  logic [23:0]             disp_n;
  logic [3:0]              ring [L];

  always_comb begin
    st_n     = st;
    digits_n = digits;
    pos_n    = pos;
    presc_n  = presc;
    step_n   = 1'b0;
    if (load) begin
      digits_n = load_data;
      pos_n    = '0;
      presc_n  = '0;
      st_n     = SHOW;
    end else begin
      case (st)
        IDLE: ;
        SHOW: begin
          if (run) begin
            st_n    = SCROLL;
            presc_n = '0;
          end
        end
        SCROLL: begin
          if (!run) begin
            st_n    = SHOW;
            presc_n = '0;
          end else if (presc == DW'(DIV - 1)) begin
            presc_n = '0;
            pos_n   = (pos == PW'(L - 1)) ? '0 : pos + PW'(1);
            step_n  = 1'b1;
          end else begin
            presc_n = presc + DW'(1);
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end

  // Window is built from next-state pos/digits so the display lands on the same edge.
  always_comb begin
    for (int unsigned e = 0; e < L; e++) begin
      ring[e] = (e < NUM_DIGITS) ? digits_n[4*e +: 4] : BLANK;
    end
  end

  always_comb begin
    int unsigned s;
    s      = 0;
    disp_n = '0;
    for (int unsigned k = 0; k < 6; k++) begin
      s = 32'(pos_n) + k;
      if (s >= L) s = s - L;
      disp_n[4*(5-k) +: 4] = ring[PW'(s)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      digits     <= {NUM_DIGITS{BLANK}};
      pos        <= '0;
      presc      <= '0;
      disp_bcd   <= {6{BLANK}};
      step_pulse <= 1'b0;
    end else begin
      st         <= st_n;
      digits     <= digits_n;
      pos        <= pos_n;
      presc      <= presc_n;
      disp_bcd   <= disp_n;
      step_pulse <= step_n;
    end
  end

  assign state = st;

endmodule
